// File: rtl/hilo_shift_register.sv
// HI/LO result register for the multiply/divide datapath: full and half loads plus a
// self-timed multi-bit shift sequencer with a busy/done handshake.
module hilo_shift_register #(
   parameter int unsigned      WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      CNT_W       = $clog2(WIDTH + 1)
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               enable,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               hi_en,
   input  logic [WIDTH/2-1:0] hi_in,
   input  logic               lo_en,
   input  logic [WIDTH/2-1:0] lo_in,
   input  logic               shift_start,
   input  logic               shift_dir,
   input  logic               shift_arith,
   input  logic [CNT_W-1:0]   shift_amt,
   input  logic               serial_in,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH/2-1:0] hi,
   output logic [WIDTH/2-1:0] lo,
   output logic               busy,
   output logic               done,
   output logic               serial_out
);

   localparam int unsigned      Half     = WIDTH / 2;
   localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] OneCnt   = CNT_W'(1);

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   amt_eff;
   logic               dir_q, dir_d;
   logic               arith_q, arith_d;
   logic               done_q, done_d;
   logic               sout_q, sout_d;
   logic               fill;

   // Requests longer than the register collapse to a full-width shift.
   assign amt_eff = (shift_amt > WidthCnt) ? WidthCnt : shift_amt;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      count_d = count_q;
      dir_d   = dir_q;
      arith_d = arith_q;
      done_d  = 1'b0;
      sout_d  = sout_q;
      fill    = 1'b0;

      case (state_q)
         StIdle: begin
            if (enable) begin
               q_d = data_in;
            end else if (shift_start) begin
               dir_d   = shift_dir;
               arith_d = shift_arith;
               if (amt_eff == '0) begin
                  done_d = 1'b1;
               end else begin
                  count_d = amt_eff;
                  state_d = StShift;
               end
            end else begin
               if (hi_en) q_d[WIDTH-1:Half] = hi_in;
               if (lo_en) q_d[Half-1:0]     = lo_in;
            end
         end

         StShift: begin
            if (!dir_q) begin
               q_d    = {q_q[WIDTH-2:0], serial_in};
               sout_d = q_q[WIDTH-1];
            end else begin
               fill   = arith_q ? q_q[WIDTH-1] : serial_in;
               q_d    = {fill, q_q[WIDTH-1:1]};
               sout_d = q_q[0];
            end
            count_d = count_q - OneCnt;
            if (count_q == OneCnt) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= StIdle;
         q_q     <= RESET_VALUE;
         count_q <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
         done_q  <= 1'b0;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
         done_q  <= done_d;
         sout_q  <= sout_d;
      end
   end

   assign q          = q_q;
   assign hi         = q_q[WIDTH-1:Half];
   assign lo         = q_q[Half-1:0];
   assign busy       = (state_q == StShift);
   assign done       = done_q;
   assign serial_out = sout_q;

endmodule

// File: doc/hilo_shift_register.md
# hilo_shift_register

Parametrised HI/LO result register for the multiply/divide datapath. It replaces the fixed 64-bit Z register with a WIDTH-bit register that supports full loads, independent HI-half and LO-half loads, and a self-timed multi-bit shift sequencer with a busy/done handshake. Sequential Booth multipliers and restoring dividers drive the shift sequencer. HI and LO are exposed directly to the HI and LO register write paths.

## Interface
- WIDTH, 64, total register width; must be even and ≥ 4.
- RESET_VALUE, 0, value loaded into q on clear.
- CNT_W, $clog2(WIDTH+1), width of the shift-amount port. Derived; do not override.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  reset, asynchronous and active-high.
- enable  in  1  load full register from data_in.
- data_in  in  WIDTH  full-load data.
- hi_en  in  1  load upper half q[WIDTH-1:WIDTH/2] from hi_in.
- hi_in  in  WIDTH/2  HI-half data.
- lo_en  in  1  load lower half q[WIDTH/2-1:0] from lo_in.
- lo_in  in  WIDTH/2  LO-half data.
- shift_start  in  1  request a shift sequence.
- shift_dir  in  1  0 = left, 1 = right.
- shift_arith  in  1  right shifts only: 1 = arithmetic, 0 = logical.
- shift_amt  in  CNT_W  number of 1-bit shifts.
- serial_in  in  1  fill bit for left shifts and logical right shifts.
- q  out  WIDTH  register contents.
- hi  out  WIDTH/2  q[WIDTH-1:WIDTH/2], combinational slice.
- lo  out  WIDTH/2  q[WIDTH/2-1:0], combinational slice.
- busy  out  1  shift sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- serial_out  out  1  bit shifted out by the most recent shift step.

## Operation
- States: IDLE and SHIFT. busy = (state == SHIFT), decoded from the state register.
- IDLE, priority at each rising edge:
  - enable: q <= data_in. hi_en, lo_en and shift_start are ignored.
  - Otherwise, shift_start: latch dir, arith and amt_eff = min(shift_amt, WIDTH) into internal registers, then:
    - amt_eff = 0: stay in IDLE, set done <= 1, q unchanged.
    - amt_eff > 0: set count <= amt_eff, go to SHIFT, q unchanged on this edge. hi_en and lo_en are ignored on this edge.
  - Otherwise, hi_en and/or lo_en: load the selected half or halves. Both halves may load on the same edge.
- SHIFT, each rising edge:
  - Apply one step using the latched dir and arith:
    - left: q <= {q[WIDTH-2:0], serial_in}, serial_out <= q[WIDTH-1].
    - right logical: q <= {serial_in, q[WIDTH-1:1]}, serial_out <= q[0].
    - right arithmetic: q <= {q[WIDTH-1], q[WIDTH-1:1]}, serial_out <= q[0]. serial_in is ignored.
  - count <= count - 1.
  - If count == 1 on this edge: go to IDLE and set done <= 1.
- serial_in is sampled live on every step, so the driver may change it each cycle.
- In SHIFT, enable, hi_en, lo_en and shift_start are ignored. Requests are dropped, not queued.
- done is 1 for exactly one cycle after completion and 0 at all other times.
- serial_out holds its value between shift steps. Loads do not change it.

## Timing
- Reset values: q = RESET_VALUE, busy = 0, done = 0, serial_out = 0, state = IDLE, count = 0. hi and lo follow q.
- Reset takes effect immediately and asynchronously, including in the middle of a sequence. The sequence is abandoned and no done pulse is generated.
- Load latency: one edge. The new value is visible on q in the cycle after the edge.
- Shift latency, with shift_start sampled at edge E0 and N = amt_eff > 0:
  - busy is high from E0 to E0+N, i.e. N cycles.
  - Shift steps occur on edges E0+1 through E0+N.
  - done and the final q are visible in the cycle after E0+N.
  - A new shift_start is accepted at E0+N+1 or later.
- Zero-amount request: done pulses in the cycle after E0, and busy stays 0.
- A shift amount greater than WIDTH is clamped to WIDTH.

## Test plan
- Reset and full load: assert clear asynchronously between edges → q = 0, busy = 0, done = 0 immediately. Then enable with data_in = 64'h0123_4567_89AB_CDEF → q = 64'h0123_4567_89AB_CDEF after 1 edge; hi = 32'h0123_4567, lo = 32'h89AB_CDEF.
- Half loads: from q = 0, hi_en with hi_in = 32'hDEAD_BEEF → q = 64'hDEAD_BEEF_0000_0000. Next, hi_en and lo_en together with 32'h1 / 32'h2 → q = 64'h0000_0001_0000_0002. enable together with hi_en → data_in wins.
- Arithmetic right shift: q = 64'h8000_0000_0000_0010, shift_amt = 4, dir = 1, arith = 1 → busy high for 4 cycles, done pulse once, q = 64'hF800_0000_0000_0001, serial_out = 0.
- Left shift with serial fill: q = 64'h1, serial_in = 1 held, shift_amt = 3, dir = 0 → q = 64'hF, serial_out = 0. shift_amt = 0 → done pulse the next cycle, busy never high, q unchanged.
- Busy lockout and clamp: during a shift_amt = 5 sequence, pulse enable and shift_start → both ignored, final q equals the pure 5-step result. shift_amt = 100 from q = all ones, logical right, serial_in = 0 → q = 0 after exactly 64 busy cycles.
- Reset mid-sequence: assert clear at the 2nd cycle of an 8-step shift → q = RESET_VALUE, busy = 0, and done never pulses.
